// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: primary writeback always wins, secondary writes queue in a FIFO.
// Optional same-cycle write-through of secondaries into an idle port: define REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pri_we,
    input  logic [4:0]  pri_reg,
    input  logic [31:0] pri_data,
    input  logic        sec_valid,
    output logic        sec_ready,
    input  logic [4:0]  sec_reg,
    input  logic [31:0] sec_data,
    input  logic [4:0]  query_reg,
    output logic        query_busy,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_reg,
    output logic [31:0] rf_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    logic [4:0]       reg_r  [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [DEPTH-1:0] live_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [STV_W-1:0] stv_cnt_r;
    logic             stall_req_r;

    logic             empty_s;
    logic             full_s;
    logic             pri_eff_s;
    logic             head_live_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             bypass_s;
    logic             blocked_s;
    logic [DEPTH-1:0] kill_s;
    logic             hit_s;
    logic [STV_W-1:0] stv_next_s;
    logic             stall_next_s;

    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign full_s      = (count_r == DEPTH_C);
    assign pri_eff_s   = pri_we && (pri_reg != 5'd0);
    assign head_live_s = !empty_s && live_r[rd_ptr_r];
    assign sec_ready   = !full_s;
    assign accept_s    = sec_valid && !full_s;
    assign blocked_s   = head_live_s && pri_eff_s;
    // A dead head leaves regardless of the primary; a live head only on a free port.
    assign pop_s       = !empty_s && (!live_r[rd_ptr_r] || !pri_eff_s);

`ifdef REGFILE_ARB_BYPASS_EN
    assign bypass_s = accept_s && empty_s && !pri_eff_s && (sec_reg != 5'd0);
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s     = accept_s && (sec_reg != 5'd0) && !bypass_s;
    assign stall_req  = stall_req_r;

    // WAW squash mask: live entries overwritten by this cycle's primary write.
    always_comb begin
        kill_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            kill_s[i] = pri_eff_s && live_r[i] && (reg_r[i] == pri_reg);
        end
    end

    // Pending-write hazard lookup over registered FIFO contents.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | (live_r[i] & (reg_r[i] == query_reg));
        end
        query_busy = hit_s && (query_reg != 5'd0);
    end

    // Write-port selection; primary has zero latency and absolute priority.
    always_comb begin
        rf_we   = 1'b0;
        rf_reg  = 5'd0;
        rf_data = 32'd0;
        if (!rst_n) begin
            rf_we = 1'b0;
        end else if (pri_eff_s) begin
            rf_we   = 1'b1;
            rf_reg  = pri_reg;
            rf_data = pri_data;
        end else if (head_live_s) begin
            rf_we   = 1'b1;
            rf_reg  = reg_r[rd_ptr_r];
            rf_data = data_r[rd_ptr_r];
        end else if (bypass_s) begin
            rf_we   = 1'b1;
            rf_reg  = sec_reg;
            rf_data = sec_data;
        end else begin
            rf_we = 1'b0;
        end
    end

    // Starvation counter and stall request next-state.
    always_comb begin
        stv_next_s   = stv_cnt_r;
        stall_next_s = stall_req_r;
        if (empty_s || pop_s) begin
            stv_next_s   = {STV_W{1'b0}};
            stall_next_s = 1'b0;
        end else if (blocked_s && (stv_cnt_r != LIMIT_C)) begin
            stv_next_s   = stv_cnt_r + STV_W'(1);
            stall_next_s = stall_req_r;
        end else begin
            stv_next_s   = stv_cnt_r;
            stall_next_s = stall_req_r || (stv_cnt_r == LIMIT_C);
        end
    end

    // FIFO storage, live bits and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_r[i]  <= 5'd0;
                data_r[i] <= 32'd0;
            end
            live_r   <= {DEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (wr_ptr_r == PTR_W'(i))) begin
                    reg_r[i]  <= sec_reg;
                    data_r[i] <= sec_data;
                    live_r[i] <= 1'b1;
                end else if (kill_s[i] || (pop_s && (rd_ptr_r == PTR_W'(i)))) begin
                    live_r[i] <= 1'b0;
                end else begin
                    live_r[i] <= live_r[i];
                end
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stv_cnt_r   <= {STV_W{1'b0}};
            stall_req_r <= 1'b0;
        end else begin
            stv_cnt_r   <= stv_next_s;
            stall_req_r <= stall_next_s;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expected port writes are queued when stimulus is driven
// and compared by a monitor whenever rf_we asserts.
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        pri_we;
    logic [4:0]  pri_reg;
    logic [31:0] pri_data;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_reg;
    logic [31:0] sec_data;
    logic [4:0]  query_reg;
    logic        query_busy;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] rf_model [32];
    int          checks;
    int          errors;

    regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pri_we(pri_we), .pri_reg(pri_reg), .pri_data(pri_data),
        .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_reg(sec_reg), .sec_data(sec_data),
        .query_reg(query_reg), .query_busy(query_busy), .stall_req(stall_req),
        .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pri(input logic we, input logic [4:0] r, input logic [31:0] d);
        pri_we = we; pri_reg = r; pri_data = d;
    endtask

    task automatic set_sec(input logic v, input logic [4:0] r, input logic [31:0] d);
        sec_valid = v; sec_reg = r; sec_data = d;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(rf_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_reg", 32'(rf_reg), 32'(mon_e.r));
                chk("wr_data", rf_data, mon_e.d);
                rf_model[rf_reg] = rf_data;
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
        rst_n = 1'b0;
        set_pri(1'b0, 5'd0, 32'd0);
        set_sec(1'b0, 5'd0, 32'd0);
        query_reg = 5'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("init_rf_we", 32'(rf_we), 32'd0);
        chk("init_sec_ready", 32'(sec_ready), 32'd1);
        chk("init_stall", 32'(stall_req), 32'd0);

        // Single secondary write with idle primary.
        set_sec(1'b1, 5'd5, 32'hA5A5_A5A5);
        query_reg = 5'd5;
        expect_wr(5'd5, 32'hA5A5_A5A5);
        #1;
        chk("sec_lat_same_cycle", 32'(rf_we), 32'(BYP));
        tick();
        set_sec(1'b0, 5'd0, 32'd0);
        #1;
        chk("sec_lat_next_cycle", 32'(rf_we), 32'(!BYP));
        chk("sec_busy_r5", 32'(query_busy), 32'(!BYP));
        tick();
        chk("sec_busy_r5_done", 32'(query_busy), 32'd0);

        // Fill FIFO behind a busy primary, then drain in order.
        for (int i = 0; i < 4; i++) begin
            set_pri(1'b1, 5'd20, 32'h100 + 32'(i));
            set_sec(1'b1, 5'(i + 1), 32'h200 + 32'(i));
            expect_wr(5'd20, 32'h100 + 32'(i));
            #1;
            chk("fill_ready", 32'(sec_ready), 32'd1);
            tick();
        end
        set_pri(1'b1, 5'd20, 32'h104);
        set_sec(1'b1, 5'd9, 32'h999);
        expect_wr(5'd20, 32'h104);
        query_reg = 5'd3;
        #1;
        chk("full_ready", 32'(sec_ready), 32'd0);
        chk("full_busy_r3", 32'(query_busy), 32'd1);
        tick();
        set_pri(1'b0, 5'd0, 32'd0);
        set_sec(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'h200 + 32'(i));
        #1;
        chk("full_pop_ready", 32'(sec_ready), 32'd0);
        tick();
        chk("drain_ready", 32'(sec_ready), 32'd1);
        repeat (3) tick();
        chk("drain_busy_r3", 32'(query_busy), 32'd0);

        // WAW squash: primary overwrites a queued r7.
        set_pri(1'b1, 5'd10, 32'h33);
        set_sec(1'b1, 5'd7, 32'h11);
        expect_wr(5'd10, 32'h33);
        query_reg = 5'd7;
        tick();
        set_sec(1'b0, 5'd0, 32'd0);
        set_pri(1'b1, 5'd7, 32'h22);
        expect_wr(5'd7, 32'h22);
        #1;
        chk("waw_busy_before", 32'(query_busy), 32'd1);
        tick();
        set_pri(1'b0, 5'd0, 32'd0);
        #1;
        chk("waw_busy_after", 32'(query_busy), 32'd0);
        chk("waw_no_write", 32'(rf_we), 32'd0);
        repeat (2) tick();

        // Starvation: head r12 blocked by continuous primary writes to r3.
        set_pri(1'b1, 5'd3, 32'h300);
        set_sec(1'b1, 5'd12, 32'hC0C0);
        expect_wr(5'd3, 32'h300);
        tick();
        set_sec(1'b0, 5'd0, 32'd0);
        for (int k = 1; k < 12; k++) begin
            set_pri(1'b1, 5'd3, 32'h300 + 32'(k));
            expect_wr(5'd3, 32'h300 + 32'(k));
            #1;
            chk("stall_window", 32'(stall_req), 32'(k >= 10));
            tick();
        end
        set_pri(1'b0, 5'd0, 32'd0);
        expect_wr(5'd12, 32'hC0C0);
        #1;
        chk("stall_held", 32'(stall_req), 32'd1);
        tick();
        chk("stall_release", 32'(stall_req), 32'd0);

        // Register $0 on both requesters.
        for (int j = 0; j < 5; j++) begin
            set_pri(1'b1, 5'd0, 32'hDEAD_0000 + 32'(j));
            set_sec(1'b1, 5'd0, 32'hBEEF);
            #1;
            chk("r0_no_write", 32'(rf_we), 32'd0);
            tick();
        end
        set_pri(1'b0, 5'd0, 32'd0);
        set_sec(1'b0, 5'd0, 32'd0);
        #1;
        chk("r0_level_ready", 32'(sec_ready), 32'd1);

        // Reset with three entries queued.
        for (int j = 0; j < 3; j++) begin
            set_pri(1'b1, 5'd15, 32'h1500 + 32'(j));
            set_sec(1'b1, 5'(20 + j), 32'h2000 + 32'(j));
            expect_wr(5'd15, 32'h1500 + 32'(j));
            tick();
        end
        set_sec(1'b0, 5'd0, 32'd0);
        set_pri(1'b1, 5'd15, 32'h15FF);
        rst_n = 1'b0;
        query_reg = 5'd20;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_busy_r20", 32'(query_busy), 32'd0);
        repeat (2) tick();
        set_pri(1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_sec_ready", 32'(sec_ready), 32'd1);
        chk("rst_stall", 32'(stall_req), 32'd0);
        for (int r = 0; r < 32; r++) begin
            query_reg = 5'(r);
            #1;
            chk("rst_busy_any", 32'(query_busy), 32'd0);
        end
        repeat (4) tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_r7", rf_model[7], 32'h22);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
